// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: FSM encoding, register select
// values and STATUS register bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic SEL_DATA   = 1'b0;
    localparam logic SEL_STATUS = 1'b1;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_SHIFTING  = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 7;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push on a full FIFO is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is deliberately left out of reset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/peripheral_uart.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, a DATA register for
// queueing bytes and a STATUS register for flags and FIFO occupancy.
module peripheral_uart
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 104,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        mem_wstrb,
    input  logic        mem_rstrb,
    input  logic        mem_sel,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        tx,
    output logic        busy
);
    localparam int          CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BIT_RELOAD = 16'(BAUD_DIV - 1);

    uart_state_t      state;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             overflow;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_dout;
    logic             push;
    logic             pop;
    logic             bit_done;
    logic             shifting;
    logic [31:0]      status_word;
    logic             unused_wdata;

    assign unused_wdata = ^{mem_wdata[31:8], mem_wdata[2:0]};

    assign bit_done = (baud_cnt == 16'd0);
    assign shifting = (state != IDLE);
    assign busy     = shifting || !fifo_empty;
    assign push     = mem_wstrb && (mem_sel == SEL_DATA);
    // Pop from IDLE, or at the last cycle of a stop bit to chain frames without a gap.
    assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .din   (mem_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status_word                                    = '0;
        status_word[STAT_FULL]                         = fifo_full;
        status_word[STAT_EMPTY]                        = fifo_empty;
        status_word[STAT_SHIFTING]                     = shifting;
        status_word[STAT_OVERFLOW]                     = overflow;
        status_word[STAT_COUNT_LSB +: STAT_COUNT_W]    = STAT_COUNT_W'(fifo_count);
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shift_reg <= fifo_dout;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        baud_cnt <= BIT_RELOAD;
                        tx       <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state    <= DATA;
                        baud_cnt <= BIT_RELOAD;
                        bit_idx  <= '0;
                        tx       <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= BIT_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            state    <= START;
                            baud_cnt <= BIT_RELOAD;
                            tx       <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A dropped DATA write is one that finds the FIFO full with no pop on the same edge.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            overflow  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (mem_wstrb && (mem_sel == SEL_STATUS) && mem_wdata[STAT_OVERFLOW]) begin
                overflow <= 1'b0;
            end
            if (mem_rstrb) begin
                mem_rdata <= (mem_sel == SEL_STATUS) ? status_word : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_peripheral_uart.sv
// Directed bench for peripheral_uart: a line monitor decodes frames on tx and
// compares them against a queue of bytes expected to be transmitted.
module tb_peripheral_uart;
    localparam int BAUD_DIV   = 4;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        RESET;
    logic        mem_wstrb;
    logic        mem_rstrb;
    logic        mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        tx;
    logic        busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         last_wr  = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    peripheral_uart #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .mem_wstrb (mem_wstrb),
        .mem_rstrb (mem_rstrb),
        .mem_sel   (mem_sel),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_data(input logic [7:0] b, input bit accept);
        mem_wstrb = 1'b1;
        mem_sel   = 1'b0;
        mem_wdata = {24'hC3A5F0, b};
        if (accept) exp_q.push_back(b);
        tick();
        last_wr   = cyc;
        mem_wstrb = 1'b0;
    endtask

    task automatic write_status(input logic [31:0] d);
        mem_wstrb = 1'b1;
        mem_sel   = 1'b1;
        mem_wdata = d;
        tick();
        mem_wstrb = 1'b0;
    endtask

    task automatic read_reg(input logic sel);
        mem_rstrb = 1'b1;
        mem_sel   = sel;
        tick();
        mem_rstrb = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int fall);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        fall = cyc;
        if (busy !== 1'b0) check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Line monitor: samples every cycle, checks each bit is held BAUD_DIV cycles.
    initial begin : tx_monitor
        logic [9:0] bits;
        logic       stable;
        logic       aborted;
        int         t0;
        forever begin
            @(posedge clk);
            #1;
            if (RESET === 1'b0 && tx === 1'b0) begin
                t0      = cyc;
                bits    = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < BAUD_DIV; c++) begin
                        if (b != 0 || c != 0) begin
                            @(posedge clk);
                            #1;
                        end
                        if (RESET !== 1'b0) aborted = 1'b1;
                        if (c == 0) bits[b] = tx;
                        else if (tx !== bits[b]) stable = 1'b0;
                    end
                end
                if (!aborted) begin
                    starts.push_back(t0);
                    check("frame_bit_stable", {31'd0, stable}, 32'd1);
                    check("frame_start_stop", {30'd0, bits[9], bits[0]}, 32'h2);
                    if (exp_q.size() == 0)
                        check("frame_unexpected", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
                    else
                        check("frame_byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int fall;
        int wr0;
        int ns;
        int gap;
        logic stayed_high;

        RESET     = 1'b1;
        mem_wstrb = 1'b0;
        mem_rstrb = 1'b0;
        mem_sel   = 1'b0;
        mem_wdata = '0;
        repeat (3) tick();
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rdata", mem_rdata, 32'd0);
        RESET = 1'b0;
        tick();
        read_reg(1'b1);
        check("status_idle", mem_rdata, 32'h0000_0002);
        read_reg(1'b0);
        check("data_read_zero", mem_rdata, 32'd0);

        // Single frame timing
        write_data(8'h55, 1'b1);
        wr0 = last_wr;
        wait_idle(100, fall);
        check("busy_fall_latency", fall - wr0, 32'd41);
        check("frame_count_1", starts.size(), 32'd1);
        check("start_latency", (starts.size() > 0) ? starts[$] - wr0 : -1, 32'd1);

        // Back-to-back frames
        write_data(8'h41, 1'b1);
        write_data(8'h42, 1'b1);
        wait_idle(200, fall);
        ns  = starts.size();
        gap = (ns >= 2) ? starts[ns-1] - starts[ns-2] : -1;
        check("b2b_gap", gap, 32'd40);
        check("frame_count_3", ns, 32'd3);

        // STATUS with two queued bytes while shifting, then read-data hold
        write_data(8'hB1, 1'b1);
        write_data(8'hB2, 1'b1);
        write_data(8'hB3, 1'b1);
        read_reg(1'b1);
        check("status_two_queued", mem_rdata, 32'h0000_0204);
        tick();
        check("rdata_hold", mem_rdata, 32'h0000_0204);
        read_reg(1'b0);
        check("data_read_shifting", mem_rdata, 32'd0);
        wait_idle(300, fall);

        // Overflow: six writes, fifth fills the FIFO, sixth is dropped
        for (int i = 0; i < 6; i++) write_data(8'h10 + 8'(i), i < 5);
        read_reg(1'b1);
        check("status_full_ovf", mem_rdata, 32'h0000_040D);
        wait_idle(400, fall);
        read_reg(1'b1);
        check("status_ovf_drained", mem_rdata, 32'h0000_000A);
        write_status(32'hFFFF_FFF7);
        read_reg(1'b1);
        check("status_ovf_kept", mem_rdata, 32'h0000_000A);
        write_status(32'h0000_0008);
        read_reg(1'b1);
        check("status_ovf_cleared", mem_rdata, 32'h0000_0002);

        // Write on a full FIFO in the same cycle as the stop-bit pop
        write_data(8'h60, 1'b1);
        wr0 = last_wr;
        for (int i = 1; i < 5; i++) write_data(8'h60 + 8'(i), 1'b1);
        read_reg(1'b1);
        check("status_full", mem_rdata, 32'h0000_0405);
        while (cyc < wr0 + 40) tick();
        write_data(8'h65, 1'b1);
        check("popwrite_edge", last_wr - wr0, 32'd41);
        read_reg(1'b1);
        check("status_full_popwrite", mem_rdata, 32'h0000_0405);
        wait_idle(600, fall);
        read_reg(1'b1);
        check("status_no_ovf", mem_rdata, 32'h0000_0002);

        // Reset in the middle of a data bit
        write_data(8'hA5, 1'b1);
        repeat (14) tick();
        #2;
        RESET = 1'b1;
        #1;
        check("midreset_tx", {31'd0, tx}, 32'd1);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_rdata", mem_rdata, 32'd0);
        @(posedge clk);
        #2;
        RESET = 1'b0;
        exp_q.delete();
        ns = starts.size();
        stayed_high = 1'b1;
        repeat (50) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
        end
        check("post_reset_quiet", {31'd0, stayed_high}, 32'd1);
        check("post_reset_no_frame", starts.size(), ns);
        read_reg(1'b1);
        check("post_reset_status", mem_rdata, 32'h0000_0002);
        write_data(8'h01, 1'b1);
        wr0 = last_wr;
        wait_idle(100, fall);
        check("post_reset_busy_fall", fall - wr0, 32'd41);
        check("post_reset_frame", starts.size(), ns + 1);

        check("all_frames_seen", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
